// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 10417;  // 100 MHz / 9600 baud
    localparam int FRAME_BITS           = 10;     // start + 8 data + stop

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue between the CPU write strobe and the serialiser; the head entry is always visible.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees room for a write.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small write FIFO, sticky overflow flag and registered serial output.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] TX_DATA,
    input  logic       TX_EN,
    output logic       TX_STATUS,
    output logic       TX_BUSY,
    output logic       TX_OVF,
    output logic       UART_TX
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    uart_state_t   state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx_q;
    logic          tx_next;
    logic          ovf_q;
    logic          baud_tc;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (TX_EN),
        .pop    (fifo_pop),
        .din    (TX_DATA),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign baud_tc = (baud_cnt == BAUD_LAST);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!fifo_empty) state_next = START;
            START: if (baud_tc) state_next = DATA;
            DATA:  if (baud_tc && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (baud_tc) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Line level for the next cycle; a stop bit ending with a queued byte chains straight into a start bit.
    always_comb begin
        fifo_pop = 1'b0;
        tx_next  = tx_q;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tx_next  = 1'b0;
                end
            end
            START: begin
                if (baud_tc) tx_next = shift[0];
            end
            DATA: begin
                if (baud_tc) tx_next = (bit_idx == 3'd7) ? 1'b1 : shift[1];
            end
            STOP: begin
                if (baud_tc) begin
                    fifo_pop = !fifo_empty;
                    tx_next  = fifo_empty;
                end
            end
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (state == IDLE || baud_tc) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && baud_tc) begin
                bit_idx <= bit_idx + 3'd1;
            end
            tx_q <= tx_next;
            if (TX_EN && fifo_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (fifo_pop) begin
            shift <= fifo_head;
        end else if (state == DATA && baud_tc) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    assign UART_TX   = tx_q;
    assign TX_STATUS = ~fifo_full;
    assign TX_BUSY   = (state != IDLE) | (fifo_count != '0);
    assign TX_OVF    = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: scoreboard of expected bytes checked against frames decoded off UART_TX.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int FRAME_CYC = 10 * CPB;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_EN = 1'b0;
    logic       TX_STATUS;
    logic       TX_BUSY;
    logic       TX_OVF;
    logic       UART_TX;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_cyc;
    int f0;
    int n0;

    logic [7:0] sb[$];
    int         starts[$];

    logic [63:0] mon_cap;
    logic [7:0]  mon_byte;
    bit          mon_abort;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .TX_DATA   (TX_DATA),
        .TX_EN     (TX_EN),
        .TX_STATUS (TX_STATUS),
        .TX_BUSY   (TX_BUSY),
        .TX_OVF    (TX_OVF),
        .UART_TX   (UART_TX)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for each of the 40 cycles of a frame carrying b.
    function automatic logic [63:0] frame_bits(input logic [7:0] b);
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (k < CPB)                 f[k] = 1'b0;
            else if (k < 9 * CPB)        f[k] = b[(k - CPB) / CPB];
            else                         f[k] = 1'b1;
        end
        return f;
    endfunction

    task automatic write(input logic [7:0] b, input bit sent);
        @(negedge sysclk);
        TX_DATA = b;
        TX_EN   = 1'b1;
        if (sent) sb.push_back(b);
        @(posedge sysclk);
        #1;
        TX_EN  = 1'b0;
        wr_cyc = cyc;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge sysclk);
    endtask

    task automatic wait_start(input int n);
        int k;
        k = 0;
        while (starts.size() < n && k < 100) begin
            @(negedge sysclk);
            #1;
            k++;
        end
        check("start_timeout", starts.size() >= n, 1);
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while (TX_BUSY !== 1'b0 && k < maxc) begin
            @(negedge sysclk);
            k++;
        end
        check("idle_timeout", k < maxc, 1);
        repeat (3) @(negedge sysclk);
    endtask

    task automatic pulse_reset();
        @(negedge sysclk);
        reset = 1'b0;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        starts.delete();
    endtask

    // Frame monitor: captures 40 line samples from each falling start edge; a reset abandons the frame.
    initial begin
        forever begin
            @(negedge sysclk);
            if (reset === 1'b1 && UART_TX === 1'b0) begin
                starts.push_back(cyc);
                mon_cap    = '0;
                mon_cap[0] = UART_TX;
                mon_abort  = 1'b0;
                for (int k = 1; k < FRAME_CYC; k++) begin
                    @(negedge sysclk);
                    if (reset !== 1'b1) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    mon_cap[k] = UART_TX;
                end
                if (!mon_abort) begin
                    check("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        mon_byte = sb.pop_front();
                        check("frame", mon_cap, frame_bits(mon_byte));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state.
        #2 reset = 1'b0;
        #1;
        check("rst_uart_tx", UART_TX, 1);
        check("rst_status",  TX_STATUS, 1);
        check("rst_busy",    TX_BUSY, 0);
        check("rst_ovf",     TX_OVF, 0);
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);

        // Single byte: latency and frame length.
        write(8'h41, 1);
        check("busy_after_wr", TX_BUSY, 1);
        wait_start(1);
        check("latency", starts[0], wr_cyc + 1);
        wait_idle(100);
        check("busy_end", TX_BUSY, 0);
        check("single_sb_empty", sb.size(), 0);
        check("single_frames", starts.size(), 1);

        // A leader frame occupies the serialiser so the following four writes fill the FIFO.
        starts.delete();
        write(8'hA5, 1);
        write(8'h01, 1);
        write(8'h02, 1);
        write(8'h03, 1);
        write(8'h04, 1);
        check("status_full", TX_STATUS, 0);
        write(8'hFF, 0);
        check("ovf_set", TX_OVF, 1);
        check("status_still_full", TX_STATUS, 0);
        f0 = starts[0];
        wait_cyc(f0 + FRAME_CYC - 1);
        check("status_before_pop", TX_STATUS, 0);
        @(negedge sysclk);
        check("status_after_pop", TX_STATUS, 1);
        wait_idle(400);
        check("burst_frames", starts.size(), 5);
        for (int i = 1; i < 5 && i < starts.size(); i++)
            check("frame_gap", starts[i] - starts[i-1], FRAME_CYC);
        check("ovf_sticky", TX_OVF, 1);
        check("burst_sb_empty", sb.size(), 0);

        // Write to a full FIFO on the very edge that pops it.
        pulse_reset();
        check("ovf_cleared", TX_OVF, 0);
        write(8'hA5, 1);
        write(8'h11, 1);
        write(8'h22, 1);
        write(8'h33, 1);
        write(8'h44, 1);
        f0 = starts[0];
        wait_cyc(f0 + FRAME_CYC - 1);
        TX_DATA = 8'hEE;
        TX_EN   = 1'b1;
        @(posedge sysclk);
        #1;
        TX_EN = 1'b0;
        check("collide_ovf", TX_OVF, 1);
        check("collide_status", TX_STATUS, 1);
        wait_idle(400);
        check("collide_frames", starts.size(), 5);
        check("collide_sb_empty", sb.size(), 0);

        // Reset mid-frame discards everything; a fresh write afterwards is clean.
        pulse_reset();
        write(8'h55, 0);
        wait_start(1);
        f0 = starts[0];
        wait_cyc(f0 + 10);
        #2 reset = 1'b0;
        #1;
        check("midrst_line", UART_TX, 1);
        check("midrst_busy", TX_BUSY, 0);
        check("midrst_status", TX_STATUS, 1);
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        n0 = starts.size();
        repeat (60) @(negedge sysclk);
        check("no_resume", starts.size(), n0);
        check("no_resume_line", UART_TX, 1);
        write(8'h0F, 1);
        wait_idle(100);
        check("post_rst_frames", starts.size(), n0 + 1);
        check("post_rst_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
